// File: rtl/fir_mac_secuencial.sv
// ============================================================================
// fir_mac_secuencial : sequential one-product-per-clock signed FIR MAC core
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fir_mac_secuencial #(
  parameter int N    = 24,
  parameter int TAPS = 16,
  parameter int AW   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     Dato_In,
  input  logic             dato_valid,
  output logic             ready,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [N-1:0]     coef_data,
  output logic [2*N-1:0]   Datos_Sum,
  output logic             sum_valid,
  output logic             overrun
);

  localparam int PW = 2 * N;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  state_t                state;
  logic signed [N-1:0]   x [TAPS];
  logic signed [N-1:0]   h [TAPS];
  logic [PW-1:0]         acc;
  logic [AW-1:0]         idx;
  logic signed [PW-1:0]  prod;
  logic [PW-1:0]         acc_next;

  // Operands are sign-extended before the multiply so the low PW bits are exact.
  assign prod     = PW'(x[idx]) * PW'(h[idx]);
  assign acc_next = acc + prod;
  assign ready    = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      Datos_Sum <= '0;
      sum_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Addresses with no matching tap simply fall through the loop.
          for (int i = 0; i < TAPS; i++) begin
            if (coef_we && (coef_addr == AW'(i))) h[i] <= coef_data;
          end
          if (dato_valid) begin
            x[0] <= Dato_In;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (dato_valid) overrun <= 1'b1;
          acc <= acc_next;
          idx <= idx + AW'(1);
          if (idx == AW'(TAPS - 1)) begin
            Datos_Sum <= acc_next;
            sum_valid <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
